// File: rtl/downsample_frame_arbiter.sv
// Frame-granular round-robin arbiter that shares one downsample core between two pixel streams.
// A grant is locked for a whole FRAME_W x FRAME_H frame, and the first beat of each frame is tagged.
module downsample_frame_arbiter #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned FRAME_W = 32,
  parameter int unsigned FRAME_H = 32
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              core_valid,
  output logic [DATA_W-1:0] core_data,
  input  logic              core_ready,
  output logic              core_sof,
  output logic              grant,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_done_id
);

  localparam int unsigned XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int unsigned YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam logic [XW-1:0] XLast = XW'(FRAME_W - 1);
  localparam logic [YW-1:0] YLast = YW'(FRAME_H - 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            grant_q, grant_d;
  logic            prio_q, prio_d;
  logic            frame_done_q, frame_done_d;
  logic            frame_done_id_q, frame_done_id_d;
  logic            prio_valid, other_valid, xfer;

  // Zero-latency pass-through of the granted stream; nothing passes while idle.
  always_comb begin
    core_valid = 1'b0;
    core_data  = grant_q ? in1_data : in0_data;
    in0_ready  = 1'b0;
    in1_ready  = 1'b0;
    core_sof   = 1'b0;
    if (state_q == StLocked) begin
      core_valid = grant_q ? in1_valid : in0_valid;
      in0_ready  = ~grant_q & core_ready;
      in1_ready  = grant_q & core_ready;
      core_sof   = core_valid && (x_q == '0) && (y_q == '0);
    end
  end

  assign xfer          = (state_q == StLocked) && core_valid && core_ready;
  assign prio_valid    = prio_q ? in1_valid : in0_valid;
  assign other_valid   = prio_q ? in0_valid : in1_valid;
  assign busy          = (state_q == StLocked);
  assign grant         = grant_q;
  assign frame_done    = frame_done_q;
  assign frame_done_id = frame_done_id_q;

  always_comb begin
    state_d         = state_q;
    x_d             = x_q;
    y_d             = y_q;
    grant_d         = grant_q;
    prio_d          = prio_q;
    frame_done_d    = 1'b0;
    frame_done_id_d = frame_done_id_q;
    unique case (state_q)
      StIdle: begin
        x_d = '0;
        y_d = '0;
        if (prio_valid) begin
          grant_d = prio_q;
          state_d = StLocked;
        end else if (other_valid) begin
          grant_d = ~prio_q;
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (xfer) begin
          if (x_q == XLast) begin
            x_d = '0;
            if (y_q == YLast) begin
              y_d             = '0;
              state_d         = StIdle;
              prio_d          = ~grant_q;
              frame_done_d    = 1'b1;
              frame_done_id_d = grant_q;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q         <= StIdle;
      x_q             <= '0;
      y_q             <= '0;
      grant_q         <= 1'b0;
      prio_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_done_id_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      x_q             <= x_d;
      y_q             <= y_d;
      grant_q         <= grant_d;
      prio_q          <= prio_d;
      frame_done_q    <= frame_done_d;
      frame_done_id_q <= frame_done_id_d;
    end
  end

endmodule

// File: tb/tb_downsample_frame_arbiter.sv
// Scoreboard bench for downsample_frame_arbiter with a 4x2 frame (8 beats).
// Stimulus pushes expected beats/frame completions; a negedge monitor pops and compares.
module tb_downsample_frame_arbiter;
  localparam int DW = 16;
  localparam int FW = 4;
  localparam int FH = 2;

  logic          CLK = 1'b0;
  logic          RESETN;
  logic          in0_valid, in1_valid, in0_ready, in1_ready;
  logic [DW-1:0] in0_data, in1_data, core_data;
  logic          core_valid, core_ready, core_sof;
  logic          grant, busy, frame_done, frame_done_id;

  always #5 CLK = ~CLK;

  downsample_frame_arbiter #(.DATA_W(DW), .FRAME_W(FW), .FRAME_H(FH)) dut (
    .CLK           (CLK),
    .RESETN        (RESETN),
    .in0_valid     (in0_valid),
    .in0_data      (in0_data),
    .in0_ready     (in0_ready),
    .in1_valid     (in1_valid),
    .in1_data      (in1_data),
    .in1_ready     (in1_ready),
    .core_valid    (core_valid),
    .core_data     (core_data),
    .core_ready    (core_ready),
    .core_sof      (core_sof),
    .grant         (grant),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_done_id (frame_done_id)
  );

  typedef struct packed {
    logic          g;
    logic          sof;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         exp_beats[$];
  int            exp_done_id[$];
  int            exp_done_cnt[$];
  logic [DW-1:0] src0[$];
  logic [DW-1:0] src1[$];
  int            checks = 0;
  int            failures = 0;
  int            beats_seen = 0;
  int            beats_pushed = 0;
  int            gap0 = 0;
  logic [DW-1:0] drop_val0 = '0;
  bit            drop_en = 1'b0;
  bit            cr_toggle = 1'b0;
  bit            f0 = 1'b0;
  bit            f1 = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_src(input int id, input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (id == 0) src0.push_back(base + DW'(i));
      else src1.push_back(base + DW'(i));
    end
  endtask

  task automatic push_frame(input int g, input logic [DW-1:0] base, input int n, input bit done);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.g   = g[0];
      b.sof = (i == 0);
      b.d   = base + DW'(i);
      exp_beats.push_back(b);
    end
    beats_pushed += n;
    if (done) begin
      exp_done_id.push_back(g);
      exp_done_cnt.push_back(beats_pushed);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_beats.size() > 0 || exp_done_id.size() > 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (exp_beats.size() > 0 || exp_done_id.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout: beats left %0d frames left %0d", exp_beats.size(),
               exp_done_id.size());
      exp_beats.delete();
      exp_done_id.delete();
      exp_done_cnt.delete();
    end
    repeat (3) @(negedge CLK);
    check("src0_consumed", src0.size(), 0);
    check("src1_consumed", src1.size(), 0);
  endtask

  // Source model: pops a beat after each accepted transfer (sampled on the prior negedge).
  initial begin
    in0_valid  = 1'b0;
    in1_valid  = 1'b0;
    in0_data   = '0;
    in1_data   = '0;
    core_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if (gap0 > 0) gap0--;
      if (f0 && src0.size() > 0) begin
        if (drop_en && src0[0] == drop_val0) gap0 = 5;
        void'(src0.pop_front());
      end
      if (f1 && src1.size() > 0) void'(src1.pop_front());
      in0_valid  = (src0.size() > 0) && (gap0 == 0);
      in0_data   = (src0.size() > 0) ? src0[0] : '0;
      in1_valid  = (src1.size() > 0);
      in1_data   = (src1.size() > 0) ? src1[0] : '0;
      core_ready = cr_toggle ? ~core_ready : 1'b1;
    end
  end

  // Monitor
  initial begin
    beat_t e;
    int    id, cnt;
    logic  p_rst = 1'b0, p_busy = 1'b0, p_req = 1'b0;
    forever begin
      @(negedge CLK);
      f0 = in0_valid & in0_ready;
      f1 = in1_valid & in1_ready;
      if (RESETN) begin
        if (!busy) begin
          check("idle_core_valid", core_valid, 0);
          check("idle_readies", {in0_ready, in1_ready}, 0);
        end else begin
          check("ungranted_ready", grant ? in0_ready : in1_ready, 0);
        end
        if (p_rst && !p_busy && p_req) check("one_bubble_lock", busy, 1);
        if (core_valid && core_ready) begin
          if (exp_beats.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got %0h expected none", core_data);
          end else begin
            e = exp_beats.pop_front();
            check("beat_data", core_data, e.d);
            check("beat_sof", core_sof, e.sof);
            check("beat_grant", grant, e.g);
          end
          beats_seen++;
        end
        if (frame_done) begin
          if (exp_done_id.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame_done: got id %0d expected none", frame_done_id);
          end else begin
            id  = exp_done_id.pop_front();
            cnt = exp_done_cnt.pop_front();
            check("done_id", frame_done_id, id);
            check("done_beat_count", beats_seen, cnt);
            check("done_busy", busy, 0);
          end
        end
      end
      p_rst  = RESETN;
      p_busy = busy;
      p_req  = in0_valid | in1_valid;
    end
  end

  initial begin
    int n;
    RESETN = 1'b1;
    #1 RESETN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_grant", grant, 0);
    check("rst_done_id", frame_done_id, 0);
    check("rst_in0_ready", in0_ready, 0);
    check("rst_in1_ready", in1_ready, 0);
    check("rst_core_valid", core_valid, 0);
    check("rst_core_sof", core_sof, 0);
    @(posedge CLK);
    #3 RESETN = 1'b1;

    // Single in0 frame.
    @(negedge CLK);
    load_src(0, 16'h0000, 8);
    push_frame(0, 16'h0000, 8, 1'b1);
    wait_drain(200);

    // in1 alone with core_ready toggling each cycle.
    cr_toggle = 1'b1;
    load_src(1, 16'h1000, 8);
    push_frame(1, 16'h1000, 8, 1'b1);
    wait_drain(300);
    cr_toggle = 1'b0;

    // Both requesters continuously valid: grants alternate 0,1,0,1.
    load_src(0, 16'h0100, 16);
    load_src(1, 16'h1100, 16);
    push_frame(0, 16'h0100, 8, 1'b1);
    push_frame(1, 16'h1100, 8, 1'b1);
    push_frame(0, 16'h0108, 8, 1'b1);
    push_frame(1, 16'h1108, 8, 1'b1);
    wait_drain(400);

    // in0 drops valid for 5 cycles after beat 3 while in1 waits.
    drop_val0 = 16'h0203;
    drop_en   = 1'b1;
    load_src(0, 16'h0200, 8);
    load_src(1, 16'h1200, 8);
    push_frame(0, 16'h0200, 8, 1'b1);
    push_frame(1, 16'h1200, 8, 1'b1);
    wait_drain(300);
    drop_en = 1'b0;

    // Full in0 frame leaves prio pointing at in1.
    load_src(0, 16'h0300, 8);
    push_frame(0, 16'h0300, 8, 1'b1);
    wait_drain(200);

    // Interrupted frame: reset once beats 0..5 are accepted.
    load_src(0, 16'h0310, 8);
    push_frame(0, 16'h0310, 6, 1'b0);
    n = 0;
    while (beats_seen != beats_pushed && n < 100) begin
      @(posedge CLK);
      #2;
      n++;
    end
    check("midframe_reached", beats_seen, beats_pushed);
    RESETN = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_core_valid", core_valid, 0);
    check("async_in0_ready", in0_ready, 0);
    check("async_in1_ready", in1_ready, 0);
    src0.delete();
    gap0 = 0;
    repeat (2) @(posedge CLK);
    #3 RESETN = 1'b1;
    @(negedge CLK);
    check("post_rst_busy", busy, 0);
    check("post_rst_done_id", frame_done_id, 0);

    // After reset prio is back to in0.
    load_src(0, 16'h0400, 8);
    load_src(1, 16'h1400, 8);
    push_frame(0, 16'h0400, 8, 1'b1);
    push_frame(1, 16'h1400, 8, 1'b1);
    wait_drain(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
